scoreboard: RTL and testbench



---
 rtl/npu_pkg.sv | 22 ++
 rtl/scoreboard_ctr.sv | 33 +++
 rtl/scoreboard.sv | 105 ++++++++++
 tb/tb_scoreboard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: engine identifiers and scoreboard sizing defaults.
package npu_pkg;

   localparam int NUM_ENG_DEF   = 6;
   localparam int MAX_OUTST_DEF = 4;
   localparam int WDOG_W_DEF    = 16;

   typedef enum logic [2:0] {
      ENG_DMA     = 3'd0,
      ENG_GEMM    = 3'd1,
      ENG_SOFTMAX = 3'd2,
      ENG_LN      = 3'd3,
      ENG_GELU    = 3'd4,
      ENG_VEC     = 3'd5
   } engine_id_e;

   // Index width that stays legal for a single-entry table.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scoreboard_ctr.sv
// One engine's outstanding-operation counter; a done pulse at zero is reported, not applied.
module scoreboard_ctr #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec_req,
   output logic [CW-1:0] cnt,
   output logic          nz,
   output logic          underflow
);

   logic dec_s;

   assign nz        = (cnt != {CW{1'b0}});
   assign dec_s     = dec_req & nz;
   assign underflow = dec_req & ~nz;

   // Outstanding count: a simultaneous issue and completion cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= {CW{1'b0}};
      end else if (inc && !dec_s) begin
         cnt <= cnt + CW'(1);
      end else if (dec_s && !inc) begin
         cnt <= cnt - CW'(1);
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/scoreboard.sv
// Per-engine in-flight tracker with issue back-pressure, idle indication for the
// barrier unit, a hung-pipeline watchdog and a sticky spurious-completion flag.
module scoreboard
   import npu_pkg::*;
#(
   parameter int NUM_ENG   = NUM_ENG_DEF,
   parameter int MAX_OUTST = MAX_OUTST_DEF,
   parameter int WDOG_W    = WDOG_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        issue_valid,
   input  logic [idx_width(NUM_ENG)-1:0] issue_eng,
   output logic                        issue_ready,
   input  logic [NUM_ENG-1:0]          eng_done,
   output logic [NUM_ENG-1:0]          busy,
   output logic                        all_idle,
   input  logic [WDOG_W-1:0]           wdog_limit,
   output logic                        wdog_err,
   output logic                        underflow_err,
   input  logic                        err_clr
);

   localparam int EW = idx_width(NUM_ENG);
   localparam int CW = $clog2(MAX_OUTST + 1);

   logic [NUM_ENG-1:0][CW-1:0] cnt_s;
   logic [NUM_ENG-1:0]         inc_s;
   logic [NUM_ENG-1:0]         underflow_s;
   logic                       fire_s;
   logic                       wd_clear_s;
   logic                       wd_hit_s;
   logic [WDOG_W-1:0]          wd_r;

   // Ready decode; out-of-range engine indices never match and so stay blocked.
   always_comb begin
      issue_ready = 1'b0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if ((issue_eng == EW'(i)) && (cnt_s[i] < CW'(MAX_OUTST))) begin
            issue_ready = 1'b1;
         end else begin
            issue_ready = issue_ready;
         end
      end
   end

   assign fire_s   = issue_valid & issue_ready;
   assign all_idle = ~(|busy) & ~fire_s;

   for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
      assign inc_s[g] = fire_s & (issue_eng == EW'(g));

      scoreboard_ctr #(
         .CW(CW)
      ) u_ctr (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc_s[g]),
         .dec_req   (eng_done[g]),
         .cnt       (cnt_s[g]),
         .nz        (busy[g]),
         .underflow (underflow_s[g])
      );
   end

   assign wd_clear_s = all_idle | (|eng_done) | (wdog_limit == {WDOG_W{1'b0}});
   assign wd_hit_s   = (wdog_limit != {WDOG_W{1'b0}}) & (wd_r == wdog_limit);

   // Watchdog: counts cycles of outstanding work without any completion, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_r <= {WDOG_W{1'b0}};
      end else if (wd_clear_s) begin
         wd_r <= {WDOG_W{1'b0}};
      end else if (wd_r != {WDOG_W{1'b1}}) begin
         wd_r <= wd_r + WDOG_W'(1);
      end else begin
         wd_r <= wd_r;
      end
   end

   // Sticky errors: a fresh set condition outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_err      <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (wd_hit_s) begin
            wdog_err <= 1'b1;
         end else if (err_clr) begin
            wdog_err <= 1'b0;
         end else begin
            wdog_err <= wdog_err;
         end
         if (|underflow_s) begin
            underflow_err <= 1'b1;
         end else if (err_clr) begin
            underflow_err <= 1'b0;
         end else begin
            underflow_err <= underflow_err;
         end
      end
   end

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for the scoreboard: each task drives one scenario
// and compares against hand-derived expectations.
module tb_scoreboard;
   import npu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic [2:0] issue_eng;
   logic       issue_ready;
   logic [5:0] eng_done;
   logic [5:0] busy;
   logic       all_idle;
   logic [15:0] wdog_limit;
   logic       wdog_err;
   logic       underflow_err;
   logic       err_clr;

   int n_cmp = 0;
   int n_bad = 0;

   scoreboard dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_eng     (issue_eng),
      .issue_ready   (issue_ready),
      .eng_done      (eng_done),
      .busy          (busy),
      .all_idle      (all_idle),
      .wdog_limit    (wdog_limit),
      .wdog_err      (wdog_err),
      .underflow_err (underflow_err),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0;
      eng_done    = 6'b000000;
      err_clr     = 1'b0;
   endtask

   task automatic test_reset();
      logic exp_rdy;
      rst = 1'b1; idle_inputs(); issue_eng = 3'd0; wdog_limit = 16'd0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      n_cmp++; if (busy !== 6'b000000) begin n_bad++; $display("FAIL rst_busy got=%b exp=%b", busy, 6'b000000); end
      n_cmp++; if (all_idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle got=%b exp=1", all_idle); end
      n_cmp++; if (wdog_err !== 1'b0 || underflow_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b%b exp=00", wdog_err, underflow_err); end
      for (int e = 0; e < 8; e++) begin
         issue_eng = 3'(e);
         exp_rdy = (e < 6) ? 1'b1 : 1'b0;
         #1;
         n_cmp++; if (issue_ready !== exp_rdy) begin n_bad++; $display("FAIL rst_ready eng=%0d got=%b exp=%b", e, issue_ready, exp_rdy); end
      end
      wdog_limit = 16'd5;
      for (int k = 0; k < 100; k++) begin
         cyc();
         if (wdog_err !== 1'b0) begin n_cmp++; n_bad++; $display("FAIL idle_wdog cyc=%0d got=%b exp=0", k, wdog_err); end
      end
      n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL idle_wdog_end got=%b exp=0", wdog_err); end
      wdog_limit = 16'd0;
   endtask

   task automatic test_gemm_full();
      idle_inputs(); cyc();
      issue_valid = 1'b1; issue_eng = ENG_GEMM;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL gemm_ready k=%0d got=%b exp=1", k, issue_ready); end
         cyc();
      end
      eng_done = 6'b000010;
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL gemm_full got=%b exp=0", issue_ready); end
      n_cmp++; if (busy !== 6'b000010) begin n_bad++; $display("FAIL gemm_busy got=%b exp=%b", busy, 6'b000010); end
      n_cmp++; if (dut.cnt_s[1] !== 3'd4) begin n_bad++; $display("FAIL gemm_cnt4 got=%0d exp=4", dut.cnt_s[1]); end
      cyc();
      issue_valid = 1'b0; eng_done = 6'b000000;
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL gemm_freed got=%b exp=1", issue_ready); end
      n_cmp++; if (dut.cnt_s[1] !== 3'd3) begin n_bad++; $display("FAIL gemm_cnt3 got=%0d exp=3", dut.cnt_s[1]); end
      eng_done = 6'b000010;
      cyc(); cyc(); cyc();
      eng_done = 6'b000000;
      #1;
      n_cmp++; if (busy !== 6'b000000 || all_idle !== 1'b1) begin n_bad++; $display("FAIL gemm_drain busy=%b idle=%b exp=000000/1", busy, all_idle); end
      n_cmp++; if (underflow_err !== 1'b0) begin n_bad++; $display("FAIL gemm_noufl got=%b exp=0", underflow_err); end
   endtask

   task automatic test_same_cycle();
      idle_inputs(); cyc();
      issue_valid = 1'b1; issue_eng = ENG_DMA;
      cyc();
      eng_done = 6'b000001;
      cyc();
      idle_inputs();
      #1;
      n_cmp++; if (dut.cnt_s[0] !== 3'd1) begin n_bad++; $display("FAIL dma_cnt got=%0d exp=1", dut.cnt_s[0]); end
      n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL dma_busy got=%b exp=1", busy[0]); end
      n_cmp++; if (underflow_err !== 1'b0) begin n_bad++; $display("FAIL dma_noufl got=%b exp=0", underflow_err); end
      issue_valid = 1'b1; issue_eng = ENG_SOFTMAX; eng_done = 6'b000100;
      cyc();
      idle_inputs();
      #1;
      n_cmp++; if (dut.cnt_s[2] !== 3'd1) begin n_bad++; $display("FAIL smax_cnt got=%0d exp=1", dut.cnt_s[2]); end
      n_cmp++; if (underflow_err !== 1'b1) begin n_bad++; $display("FAIL smax_ufl got=%b exp=1", underflow_err); end
      n_cmp++; if (busy !== 6'b000101) begin n_bad++; $display("FAIL smax_busy got=%b exp=%b", busy, 6'b000101); end
      eng_done = 6'b000101; err_clr = 1'b1;
      cyc();
      idle_inputs();
      #1;
      n_cmp++; if (underflow_err !== 1'b0 || busy !== 6'b000000) begin n_bad++; $display("FAIL smax_clr ufl=%b busy=%b exp=0/000000", underflow_err, busy); end
   endtask

   task automatic test_barrier();
      int  c;
      logic seen;
      idle_inputs(); cyc();
      issue_valid = 1'b1; issue_eng = ENG_LN;
      #1;
      n_cmp++; if (all_idle !== 1'b0) begin n_bad++; $display("FAIL ln_fire_idle got=%b exp=0", all_idle); end
      cyc();
      issue_valid = 1'b0;
      c = 1; seen = 1'b0;
      while (c <= 10 && !seen) begin
         eng_done = (c == 3) ? 6'b001000 : 6'b000000;
         #1;
         if (all_idle === 1'b1) seen = 1'b1;
         else begin cyc(); c++; end
      end
      eng_done = 6'b000000;
      n_cmp++; if (!seen || c !== 4) begin n_bad++; $display("FAIL barrier_stall got=%0d exp=4", c); end
   endtask

   task automatic test_watchdog();
      idle_inputs(); cyc();
      wdog_limit = 16'd8;
      issue_valid = 1'b1; issue_eng = ENG_GELU;
      cyc();
      issue_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL wdog_early t+%0d got=%b exp=0", k, wdog_err); end
         cyc();
      end
      n_cmp++; if (wdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_rise got=%b exp=1", wdog_err); end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL wdog_clr got=%b exp=0", wdog_err); end
      eng_done = 6'b010000;
      cyc();
      eng_done = 6'b000000;
      issue_valid = 1'b1;
      cyc();
      issue_valid = 1'b0;
      repeat (7) cyc();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      n_cmp++; if (wdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_set_wins got=%b exp=1", wdog_err); end
      eng_done = 6'b010000; err_clr = 1'b1;
      cyc();
      idle_inputs(); wdog_limit = 16'd0;
      #1;
      n_cmp++; if (wdog_err !== 1'b0 || all_idle !== 1'b1) begin n_bad++; $display("FAIL wdog_end err=%b idle=%b exp=0/1", wdog_err, all_idle); end
   endtask

   task automatic test_reset_mid();
      idle_inputs(); cyc();
      wdog_limit = 16'd2;
      issue_valid = 1'b1; issue_eng = ENG_VEC;
      cyc(); cyc(); cyc();
      issue_valid = 1'b0; eng_done = 6'b000001;
      cyc();
      eng_done = 6'b000000;
      #1;
      n_cmp++; if (wdog_err !== 1'b1 || underflow_err !== 1'b1) begin n_bad++; $display("FAIL pre_rst_err got=%b%b exp=11", wdog_err, underflow_err); end
      n_cmp++; if (dut.cnt_s[5] !== 3'd3) begin n_bad++; $display("FAIL pre_rst_cnt got=%0d exp=3", dut.cnt_s[5]); end
      rst = 1'b1; issue_valid = 1'b1; issue_eng = ENG_VEC;
      cyc();
      rst = 1'b0; idle_inputs(); wdog_limit = 16'd0;
      #1;
      n_cmp++; if (busy !== 6'b000000 || dut.cnt_s[5] !== 3'd0) begin n_bad++; $display("FAIL post_rst_cnt busy=%b cnt5=%0d exp=000000/0", busy, dut.cnt_s[5]); end
      n_cmp++; if (all_idle !== 1'b1) begin n_bad++; $display("FAIL post_rst_idle got=%b exp=1", all_idle); end
      n_cmp++; if (wdog_err !== 1'b0 || underflow_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_err got=%b%b exp=00", wdog_err, underflow_err); end
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got=%b exp=1", issue_ready); end
   endtask

   initial begin
      test_reset();
      test_gemm_full();
      test_same_cycle();
      test_barrier();
      test_watchdog();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
